// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit saturating counters,
// execute-stage resolution, mispredict flag and branch/mispredict statistics.
module branch_predictor #(
    parameter int ADDR_WIDTH = 32,
    parameter int ENTRIES    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_WIDTH-1:0] i_pc_f,
    output logic                  o_pred_taken,
    output logic                  o_pred_hit,
    output logic [ADDR_WIDTH-1:0] o_next_pc,
    input  logic                  i_upd_en,
    input  logic [ADDR_WIDTH-1:0] i_upd_pc,
    input  logic                  i_upd_taken,
    input  logic [ADDR_WIDTH-1:0] i_upd_target,
    input  logic                  i_upd_pred_taken,
    input  logic [ADDR_WIDTH-1:0] i_upd_pred_target,
    output logic                  o_mispredict,
    output logic [31:0]           o_br_count,
    output logic [31:0]           o_mispred_count
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TAG = ADDR_WIDTH - IDX - 2;

    logic                  r_valid  [ENTRIES];
    logic [TAG-1:0]        r_tag    [ENTRIES];
    logic [ADDR_WIDTH-1:0] r_target [ENTRIES];
    logic [1:0]            r_ctr    [ENTRIES];
    logic [31:0]           r_br_count;
    logic [31:0]           r_mispred_count;

    logic [IDX-1:0] w_f_idx, w_u_idx;
    logic [TAG-1:0] w_f_tag, w_u_tag;
    logic           w_f_hit, w_u_hit, w_mispredict;
    logic           w_unused;

    assign w_f_idx = i_pc_f[IDX+1:2];
    assign w_f_tag = i_pc_f[ADDR_WIDTH-1:IDX+2];
    assign w_u_idx = i_upd_pc[IDX+1:2];
    assign w_u_tag = i_upd_pc[ADDR_WIDTH-1:IDX+2];
    assign w_unused = ^{i_pc_f[1:0], i_upd_pc[1:0]};

    // Prediction reads the registered table only, so a same-cycle update is not bypassed.
    assign w_f_hit      = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign o_pred_hit   = w_f_hit;
    assign o_pred_taken = w_f_hit && r_ctr[w_f_idx][1];
    assign o_next_pc    = o_pred_taken ? r_target[w_f_idx] : i_pc_f + ADDR_WIDTH'(4);

    assign w_u_hit      = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
    assign w_mispredict = i_upd_en && ((i_upd_taken != i_upd_pred_taken) ||
                          (i_upd_taken && (i_upd_target != i_upd_pred_target)));
    assign o_mispredict = w_mispredict;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < ENTRIES; k++) begin
                r_valid[k]  <= 1'b0;
                r_tag[k]    <= '0;
                r_target[k] <= '0;
                r_ctr[k]    <= 2'b01;
            end
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else if (i_upd_en) begin
            r_br_count <= r_br_count + 32'd1;
            if (w_mispredict)
                r_mispred_count <= r_mispred_count + 32'd1;
            if (w_u_hit) begin
                if (i_upd_taken) begin
                    r_target[w_u_idx] <= i_upd_target;
                    if (r_ctr[w_u_idx] != 2'b11)
                        r_ctr[w_u_idx] <= r_ctr[w_u_idx] + 2'd1;
                end else if (r_ctr[w_u_idx] != 2'b00) begin
                    r_ctr[w_u_idx] <= r_ctr[w_u_idx] - 2'd1;
                end
            end else if (i_upd_taken) begin
                // Taken miss allocates, evicting whatever aliased into this index.
                r_valid[w_u_idx]  <= 1'b1;
                r_tag[w_u_idx]    <= w_u_tag;
                r_target[w_u_idx] <= i_upd_target;
                r_ctr[w_u_idx]    <= 2'b10;
            end
        end
    end

    assign o_br_count      = r_br_count;
    assign o_mispred_count = r_mispred_count;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16, ADDR_WIDTH=32).
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_f;
    logic        pred_taken, pred_hit;
    logic [31:0] next_pc;
    logic        upd_en, upd_taken, upd_pred_taken;
    logic [31:0] upd_pc, upd_target, upd_pred_target;
    logic        mispredict;
    logic [31:0] br_count, mispred_count;

    int n_cmp = 0;
    int n_err = 0;

    branch_predictor #(.ADDR_WIDTH(32), .ENTRIES(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_pc_f(pc_f),
        .o_pred_taken(pred_taken), .o_pred_hit(pred_hit), .o_next_pc(next_pc),
        .i_upd_en(upd_en), .i_upd_pc(upd_pc), .i_upd_taken(upd_taken),
        .i_upd_target(upd_target), .i_upd_pred_taken(upd_pred_taken),
        .i_upd_pred_target(upd_pred_target), .o_mispredict(mispredict),
        .o_br_count(br_count), .o_mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an update for one cycle, check mispredict before the edge, retire it.
    task automatic do_upd(input string tag, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                          input logic exp_mp);
        upd_en = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
        upd_pred_taken = ptk; upd_pred_target = ptgt;
        #1 chk(tag, {31'd0, mispredict}, {31'd0, exp_mp});
        @(posedge clk); #1;
        upd_en = 1'b0;
    endtask

    task automatic chk_pred(input string tag, input logic [31:0] pc, input logic hit,
                            input logic tk, input logic [31:0] npc);
        pc_f = pc;
        #1;
        chk({tag, "_hit"}, {31'd0, pred_hit}, {31'd0, hit});
        chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, tk});
        chk({tag, "_npc"}, next_pc, npc);
    endtask

    initial begin
        rst = 1'b1; pc_f = 32'h100; upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b1;
        upd_target = 32'h44; upd_pred_taken = 1'b0; upd_pred_target = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state; mismatched update fields must not flag without upd_en
        chk_pred("rst", 32'h100, 1'b0, 1'b0, 32'h104);
        chk("rst_br", br_count, 32'd0);
        chk("rst_mp", mispred_count, 32'd0);
        chk("mp_no_en", {31'd0, mispredict}, 32'd0);

        // Taken allocation at 0x100 (ctr=2)
        do_upd("alloc_mp", 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1);
        chk_pred("alloc", 32'h100, 1'b1, 1'b1, 32'h80);
        chk("alloc_mpc", mispred_count, 32'd1);
        chk("alloc_br", br_count, 32'd1);

        // Saturate up: four correctly predicted taken updates -> ctr=3
        for (int k = 0; k < 4; k++)
            do_upd("sat_up_mp", 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
        // Two not-taken: 3->2 still taken, 2->1 not taken but hit
        do_upd("nt1_mp", 32'h100, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
        chk_pred("ctr2", 32'h100, 1'b1, 1'b1, 32'h80);
        do_upd("nt2_mp", 32'h100, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
        chk_pred("ctr1", 32'h100, 1'b1, 1'b0, 32'h104);
        // Three more not-taken -> floor at 0; one taken then only reaches 1
        for (int k = 0; k < 3; k++)
            do_upd("sat_dn_mp", 32'h100, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0);
        do_upd("floor_mp", 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1);
        chk_pred("floor", 32'h100, 1'b1, 1'b0, 32'h104);
        chk("floor_br", br_count, 32'd11);
        chk("floor_mpc", mispred_count, 32'd4);

        // Not-taken miss does not allocate or disturb the aliasing entry
        do_upd("ntmiss_mp", 32'h200, 1'b0, 32'h0, 1'b0, 32'h204, 1'b0);
        chk_pred("ntmiss", 32'h200, 1'b0, 1'b0, 32'h204);
        pc_f = 32'h100; #1 chk("ntmiss_keep", {31'd0, pred_hit}, 32'd1);

        // Taken miss at 0x140 (same index) evicts 0x100
        do_upd("alias_mp", 32'h140, 1'b1, 32'h40, 1'b0, 32'h144, 1'b1);
        chk_pred("evicted", 32'h100, 1'b0, 1'b0, 32'h104);
        chk_pred("alias", 32'h140, 1'b1, 1'b1, 32'h40);

        // Re-allocate 0x100 -> 0x80, then target mismatch with same-cycle read
        do_upd("realloc_mp", 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1);
        pc_f = 32'h100;
        upd_en = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h90;
        upd_pred_taken = 1'b1; upd_pred_target = 32'h80;
        #1;
        chk("tgt_mp", {31'd0, mispredict}, 32'd1);
        chk("tgt_npc_same", next_pc, 32'h80);
        @(posedge clk); #1 upd_en = 1'b0;
        #1 chk("tgt_npc_next", next_pc, 32'h90);
        chk("tgt_br", br_count, 32'd15);
        chk("tgt_mpc", mispred_count, 32'd7);

        // Reset beats a simultaneous update; mispredict still combinational
        rst = 1'b1;
        upd_en = 1'b1; upd_pc = 32'h300; upd_taken = 1'b1; upd_target = 32'h500;
        upd_pred_taken = 1'b0; upd_pred_target = 32'h304;
        #1 chk("rst_mp_comb", {31'd0, mispredict}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; upd_en = 1'b0;
        chk_pred("rst_upd", 32'h300, 1'b0, 1'b0, 32'h304);
        chk("rst_upd_br", br_count, 32'd0);
        chk("rst_upd_mpc", mispred_count, 32'd0);

        // Counter wrap via backdoor preload
        force dut.r_br_count = 32'hFFFF_FFFF;
        #1 release dut.r_br_count;
        do_upd("wrap_mp", 32'h200, 1'b0, 32'h0, 1'b0, 32'h204, 1'b0);
        chk("wrap_br", br_count, 32'd0);
        chk("wrap_mpc", mispred_count, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage dynamic branch predictor: a direct-mapped branch target buffer with 2-bit saturating counters. The fetch stage reads a prediction for the current PC every cycle. The execute stage writes back the resolved outcome: the control-flow unit's `br_taken`, plus the actual target. The block flags mispredictions for pipeline flush and keeps branch and mispredict statistics.

## Interface
- `ADDR_WIDTH`, 32, PC and target width.
- `ENTRIES`, 16, number of BTB entries; power of two, ≥2. `IDX = log2(ENTRIES)`, `TAG = ADDR_WIDTH-IDX-2`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pc_f`  in  ADDR_WIDTH  fetch PC (word aligned, bits[1:0] ignored).
- `pred_taken`  out  1  prediction for `pc_f`: taken.
- `pred_hit`  out  1  `pc_f` hit a valid entry.
- `next_pc`  out  ADDR_WIDTH  predicted next fetch PC.
- `upd_en`  in  1  execute stage is retiring a control-flow instruction this cycle (CFU op ≠ NB).
- `upd_pc`  in  ADDR_WIDTH  PC of that instruction.
- `upd_taken`  in  1  resolved outcome (`br_taken`; 1 for JAL/JALR).
- `upd_target`  in  ADDR_WIDTH  resolved target address.
- `upd_pred_taken`  in  1  `pred_taken` carried down the pipe with the instruction.
- `upd_pred_target`  in  ADDR_WIDTH  `next_pc` carried down the pipe with the instruction.
- `mispredict`  out  1  redirect or flush required for the instruction being updated.
- `br_count`  out  32  number of updates accepted since reset.
- `mispred_count`  out  32  number of mispredictions since reset.

## Operation
- **Entry contents:** `valid`, `tag[TAG]`, `target[ADDR_WIDTH]`, `ctr[2]`.
- **Indexing:** index = `pc[IDX+1:2]`; tag = `pc[ADDR_WIDTH-1:IDX+2]`.
- **Predict (combinational from registered table):**
  - `pred_hit = valid[i] && tag[i]==tag(pc_f)`.
  - `pred_taken = pred_hit && ctr[i][1]`.
  - `next_pc = pred_taken ? target[i] : pc_f+4`, with addition modulo 2^ADDR_WIDTH.
- **Update on `upd_en`, hit (valid and tag match):**
  - Taken: `ctr` increments, saturating at 3, and `target` is overwritten with `upd_target`.
  - Not taken: `ctr` decrements, saturating at 0; `target` is unchanged.
- **Update on `upd_en`, miss:**
  - Taken: the entry is allocated, replacing any previous contents: `valid=1`, tag written, `target=upd_target`, `ctr=2'b10`.
  - Not taken: no table change.
- **mispredict (combinational):** `upd_en && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target))`.
- **Counters:** `br_count` increments on every `upd_en`. `mispred_count` increments when `mispredict`=1. Both wrap from 2^32-1 to 0.

## Timing
- Prediction has zero latency: `pred_*` and `next_pc` follow `pc_f` combinationally.
- Table writes and counter increments take effect on the edge after `upd_en`; they are visible to `pc_f` from the next cycle.
- Same-cycle read and update of the same index: the prediction reflects the pre-update contents (no bypass).
- `mispredict` is valid in the same cycle as `upd_en`; it is 0 whenever `upd_en`=0.
- **Reset:** at the first edge with `rst`=1, all entries become `valid=0`, `tag=0`, `target=0`, `ctr=2'b01`, and both counters become 0.
- **Outputs during and after reset:** `pred_hit`=0, `pred_taken`=0 and `next_pc`=`pc_f`+4. `mispredict` still evaluates combinationally during reset.
- **`rst` wins over `upd_en`:** an update presented in a reset cycle is discarded and not counted.
- **Aliasing:** PCs that share an index but differ in tag evict each other only on a taken miss.
- There is no handshake and no stall: an update is always accepted in the cycle `upd_en` is high.

## Test plan
- **Reset state:** reset, then `pc_f`=0x100 → `pred_hit`=0, `pred_taken`=0, `next_pc`=0x104, `br_count`=0, `mispred_count`=0.
- **Taken allocation:**
  - Update `upd_pc`=0x100, taken, `upd_target`=0x80, `upd_pred_taken`=0 → `mispredict`=1.
  - Next cycle, `pc_f`=0x100 → `pred_hit`=1, `pred_taken`=1, `next_pc`=0x80, `mispred_count`=1.
- **Counter saturation:**
  - Four more taken updates at 0x100 → `ctr`=3.
  - Then two not-taken updates → `ctr`=1 and `pred_taken`=0, with `pred_hit` still 1.
  - Three further not-taken updates → `ctr` stays 0.
- **Not-taken miss and aliasing:**
  - Not-taken update at 0x200 → no allocation; `pred_hit`(0x200)=0.
  - With `ENTRIES`=16, a taken update at 0x140 (same index as 0x100) → 0x100 now misses, 0x140 hits.
- **Target mismatch and same-cycle read:**
  - Hit entry at 0x100 with target 0x80; update taken with `upd_target`=0x90, `upd_pred_taken`=1, `upd_pred_target`=0x80 → `mispredict`=1.
  - `next_pc` shows 0x80 in the update cycle and 0x90 in the following cycle.
- **Reset and counter wrap:**
  - `rst` asserted together with `upd_en` → no allocation, `br_count` stays 0.
  - Force `br_count`=0xFFFFFFFF (long run or backdoor), then one update → 0.
